// File: rtl/clk_lock_rst_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_lock_rst_seq_if                                             |
// | Brief    : Lock-status / reset-sequencer signal bundle                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface clk_lock_rst_seq_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  clk_locked_i;
  logic                  sw_rst_i;
  logic                  clr_stat_i;
  logic                  rst_core_n_o;
  logic                  rst_mac_n_o;
  logic                  ready_o;
  logic                  lock_lost_o;
  logic [LOSS_CNT_W-1:0] loss_cnt_o;
  logic [1:0]            state_o;

  modport master (
    output clk_locked_i, sw_rst_i, clr_stat_i,
    input  rst_core_n_o, rst_mac_n_o, ready_o, lock_lost_o, loss_cnt_o, state_o
  );

  modport slave (
    input  clk_locked_i, sw_rst_i, clr_stat_i,
    output rst_core_n_o, rst_mac_n_o, ready_o, lock_lost_o, loss_cnt_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/clk_lock_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_lock_rst_seq                                                |
// | Brief    : Qualifies clock-manager lock, sequences core then MAC reset     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clk_lock_rst_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_GAP       = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  wire logic           clk_in,
  input  wire logic           rst_in,
  clk_lock_rst_seq_if.slave   lk
);

  localparam int c_MAX_CYC = (STABLE_CYCLES > RST_GAP) ? STABLE_CYCLES : RST_GAP;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;

  localparam logic [c_CNT_W-1:0]    c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]    c_GAP_LAST    = c_CNT_W'(RST_GAP - 1);
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [LOSS_CNT_W-1:0] c_LOSS_MAX    = '1;
  localparam logic [LOSS_CNT_W-1:0] c_LOSS_ONE    = LOSS_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_GAP    = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic                   w_loss;
  logic                   r_core_n;
  logic                   r_mac_n;
  logic                   r_ready;
  logic                   r_lost;
  logic [LOSS_CNT_W-1:0]  r_loss_cnt;
  logic                   w_lost_base;
  logic [LOSS_CNT_W-1:0]  w_loss_base;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], lk.clk_locked_i};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss      = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (!lk.sw_rst_i && w_locked_s) w_state_nxt = ST_STABLE;
      end
      ST_STABLE: begin
        // A dropout while qualifying is a restart, not a loss.
        if (!w_locked_s || lk.sw_rst_i) w_state_nxt = ST_WAIT;
        else if (r_cnt == c_STABLE_LAST) w_state_nxt = ST_GAP;
        else w_cnt_nxt = r_cnt + c_CNT_ONE;
      end
      ST_GAP: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT;
          w_loss      = 1'b1;
        end else if (lk.sw_rst_i) w_state_nxt = ST_WAIT;
        else if (r_cnt == c_GAP_LAST) w_state_nxt = ST_RUN;
        else w_cnt_nxt = r_cnt + c_CNT_ONE;
      end
      ST_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT;
          w_loss      = 1'b1;
        end else if (lk.sw_rst_i) w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_WAIT;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Clear is applied before the increment, so a coincident loss yields a count of one.
  assign w_lost_base = lk.clr_stat_i ? 1'b0 : r_lost;
  assign w_loss_base = lk.clr_stat_i ? '0   : r_loss_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_WAIT;
      r_cnt      <= '0;
      r_core_n   <= 1'b0;
      r_mac_n    <= 1'b0;
      r_ready    <= 1'b0;
      r_lost     <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_core_n <= (w_state_nxt == ST_GAP) || (w_state_nxt == ST_RUN);
      r_mac_n  <= (w_state_nxt == ST_RUN);
      r_ready  <= (w_state_nxt == ST_RUN);
      r_lost   <= w_loss | w_lost_base;
      if (w_loss && (w_loss_base != c_LOSS_MAX)) r_loss_cnt <= w_loss_base + c_LOSS_ONE;
      else r_loss_cnt <= w_loss_base;
    end
  end

  assign lk.rst_core_n_o = r_core_n;
  assign lk.rst_mac_n_o  = r_mac_n;
  assign lk.ready_o      = r_ready;
  assign lk.lock_lost_o  = r_lost;
  assign lk.loss_cnt_o   = r_loss_cnt;
  assign lk.state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clk_lock_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_clk_lock_rst_seq                                             |
// | Brief    : Scoreboard bench for the lock-qualified reset sequencer         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_clk_lock_rst_seq;

  logic clk_in;
  logic rst_in;
  int   edge_cnt;
  int   tests;
  int   fails;

  clk_lock_rst_seq_if #(.LOSS_CNT_W(2)) lk ();

  clk_lock_rst_seq #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .RST_GAP       (4),
    .LOSS_CNT_W    (2)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .lk     (lk)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial edge_cnt = 0;
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  // Expected bits: {core_n, mac_n, ready, lost, cnt[1:0], state[1:0]}
  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] exp;
  } chk_t;

  chk_t q[$];
  chk_t mon_c;
  logic [7:0] got;

  task automatic expect_at(input int cyc, input string nm, input bit core, input bit mac,
                           input bit rdy, input bit lost, input int cnt, input int st);
    chk_t c;
    c.cyc  = cyc;
    c.name = nm;
    c.exp  = {core, mac, rdy, lost, 2'(cnt), 2'(st)};
    q.push_back(c);
  endtask

  task automatic wait_neg(input int e);
    while (edge_cnt < e) @(negedge clk_in);
  endtask

  always @(negedge clk_in) begin
    got = {lk.rst_core_n_o, lk.rst_mac_n_o, lk.ready_o, lk.lock_lost_o, lk.loss_cnt_o, lk.state_o};
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      mon_c = q.pop_front();
      tests = tests + 1;
      if (mon_c.cyc < edge_cnt) begin
        fails = fails + 1;
        $display("FAIL %s: check for edge %0d not sampled (now %0d)", mon_c.name, mon_c.cyc, edge_cnt);
      end else if (got !== mon_c.exp) begin
        fails = fails + 1;
        $display("FAIL %s @edge %0d: got core=%b mac=%b rdy=%b lost=%b cnt=%0d st=%0d, expected core=%b mac=%b rdy=%b lost=%b cnt=%0d st=%0d",
                 mon_c.name, edge_cnt, got[7], got[6], got[5], got[4], got[3:2], got[1:0],
                 mon_c.exp[7], mon_c.exp[6], mon_c.exp[5], mon_c.exp[4], mon_c.exp[3:2], mon_c.exp[1:0]);
      end
    end
  end

  // Lock loss from RUN; lock restored one cycle later, full requalification follows.
  task automatic do_loss(input string nm, input int cnt, input bit clr);
    int f;
    lk.clk_locked_i = 1'b0;
    f = edge_cnt + 1;
    wait_neg(f + 1);
    lk.clk_locked_i = 1'b1;
    lk.clr_stat_i   = clr;
    expect_at(f + 2, {nm, "_loss"}, 0, 0, 0, 1, cnt, 0);
    wait_neg(f + 2);
    lk.clr_stat_i = 1'b0;
    expect_at(f + 16, {nm, "_run"}, 1, 1, 1, 1, cnt, 3);
    wait_neg(f + 17);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int b;
    int d;
    int f;
    int n;
    tests = 0;
    fails = 0;
    rst_in          = 1'b0;
    lk.clk_locked_i = 1'b0;
    lk.sw_rst_i     = 1'b0;
    lk.clr_stat_i   = 1'b0;

    // Power-up
    expect_at(1, "reset", 0, 0, 0, 0, 0, 0);
    expect_at(2, "reset_hold", 0, 0, 0, 0, 0, 0);
    wait_neg(3);
    rst_in          = 1'b1;
    lk.clk_locked_i = 1'b1;
    b = edge_cnt + 1;
    expect_at(b + 1,  "pu_wait",       0, 0, 0, 0, 0, 0);
    expect_at(b + 2,  "pu_stable",     0, 0, 0, 0, 0, 1);
    expect_at(b + 9,  "pu_stable_end", 0, 0, 0, 0, 0, 1);
    expect_at(b + 10, "pu_core",       1, 0, 0, 0, 0, 2);
    expect_at(b + 13, "pu_gap_end",    1, 0, 0, 0, 0, 2);
    expect_at(b + 14, "pu_run",        1, 1, 1, 0, 0, 3);
    wait_neg(b + 15);

    // Software reset in RUN, then a 2-cycle dropout during STABLE
    lk.sw_rst_i = 1'b1;
    b = edge_cnt + 1;
    expect_at(b, "sw_run_wait", 0, 0, 0, 0, 0, 0);
    wait_neg(b);
    lk.sw_rst_i = 1'b0;
    expect_at(b + 1, "sw_restable", 0, 0, 0, 0, 0, 1);
    wait_neg(b + 3);
    lk.clk_locked_i = 1'b0;
    d = edge_cnt + 1;
    wait_neg(d + 1);
    lk.clk_locked_i = 1'b1;
    expect_at(d + 2,  "drop_wait",     0, 0, 0, 0, 0, 0);
    expect_at(d + 3,  "drop_hold",     0, 0, 0, 0, 0, 0);
    expect_at(d + 4,  "requal",        0, 0, 0, 0, 0, 1);
    expect_at(d + 11, "requal_stable", 0, 0, 0, 0, 0, 1);
    expect_at(d + 12, "requal_core",   1, 0, 0, 0, 0, 2);
    expect_at(d + 16, "requal_run",    1, 1, 1, 0, 0, 3);
    wait_neg(d + 17);

    // Lock loss in RUN
    lk.clk_locked_i = 1'b0;
    f = edge_cnt + 1;
    expect_at(f + 1, "loss_f1", 1, 1, 1, 0, 0, 3);
    wait_neg(f + 1);
    lk.clk_locked_i = 1'b1;
    expect_at(f + 2,  "loss_f2",    0, 0, 0, 1, 1, 0);
    expect_at(f + 3,  "loss_wait",  0, 0, 0, 1, 1, 0);
    expect_at(f + 4,  "loss_requal",0, 0, 0, 1, 1, 1);
    expect_at(f + 12, "loss_core",  1, 0, 0, 1, 1, 2);
    expect_at(f + 16, "loss_run",   1, 1, 1, 1, 1, 3);
    wait_neg(f + 17);

    // Lock loss plus sw_rst_i in the same GAP cycle
    lk.sw_rst_i = 1'b1;
    n = edge_cnt + 1;
    expect_at(n, "sw2_wait", 0, 0, 0, 1, 1, 0);
    wait_neg(n);
    lk.sw_rst_i = 1'b0;
    expect_at(n + 1, "sw2_stable", 0, 0, 0, 1, 1, 1);
    wait_neg(n + 8);
    lk.clk_locked_i = 1'b0;
    expect_at(n + 9,  "gap_enter", 1, 0, 0, 1, 1, 2);
    expect_at(n + 10, "gap_hold",  1, 0, 0, 1, 1, 2);
    wait_neg(n + 10);
    lk.sw_rst_i = 1'b1;
    expect_at(n + 11, "gap_loss_sw", 0, 0, 0, 1, 2, 0);
    wait_neg(n + 11);
    lk.sw_rst_i     = 1'b0;
    lk.clk_locked_i = 1'b1;
    expect_at(n + 12, "gap_wait",   0, 0, 0, 1, 2, 0);
    expect_at(n + 14, "gap_requal", 0, 0, 0, 1, 2, 1);
    expect_at(n + 22, "gap_core",   1, 0, 0, 1, 2, 2);
    expect_at(n + 26, "gap_run",    1, 1, 1, 1, 2, 3);
    wait_neg(n + 27);

    // Saturation, then clear coincident with a loss, then clear alone
    do_loss("sat3", 3, 1'b0);
    do_loss("sat4", 3, 1'b0);
    do_loss("sat5", 3, 1'b0);
    do_loss("clr_loss", 1, 1'b1);
    lk.clr_stat_i = 1'b1;
    b = edge_cnt + 1;
    expect_at(b, "clr_alone", 1, 1, 1, 0, 0, 3);
    wait_neg(b);
    lk.clr_stat_i = 1'b0;
    wait_neg(b + 1);

    // Asynchronous reset mid-GAP
    lk.clk_locked_i = 1'b0;
    f = edge_cnt + 1;
    wait_neg(f + 1);
    lk.clk_locked_i = 1'b1;
    expect_at(f + 2,  "pre_rst_loss", 0, 0, 0, 1, 1, 0);
    expect_at(f + 12, "pre_rst_gap",  1, 0, 0, 1, 1, 2);
    wait_neg(f + 12);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    expect_at(f + 13, "async_rst",  0, 0, 0, 0, 0, 0);
    expect_at(f + 14, "rst_hold",   0, 0, 0, 0, 0, 0);
    wait_neg(f + 15);
    rst_in = 1'b1;
    wait_neg(f + 17);

    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d checks left unsampled, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_lock_rst_seq.md
Name: clk_lock_rst_seq

Overview:
- Consumer end of the clock-management lock interface.
- Synchronises the asynchronous MMCM/PLL `clk_locked` into the generated clock domain and requires the lock to be stable before releasing resets.
- Releases the core reset first, then the MAC reset after a fixed gap.
- Re-asserts both resets on lock loss or software request, and keeps lock-loss statistics for the Ethernet subsystem.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count on clk_locked_i; legal range ≥2.
- STABLE_CYCLES, 1024: consecutive locked cycles required before core reset release; legal range ≥1.
- RST_GAP, 16: cycles between core reset release and MAC reset release; legal range ≥1.
- LOSS_CNT_W, 8: width of the lock-loss event counter.

Ports:
- clk_in  input  1  generated clock (e.g. 125 MHz) that all logic runs on
- rst_in  input  1  asynchronous, active-low reset
- clk_locked_i  input  1  lock indication from the clock manager; asynchronous to clk_in
- sw_rst_i  input  1  synchronous software reset request, level
- clr_stat_i  input  1  synchronous clear of lock_lost_o and loss_cnt_o
- rst_core_n_o  output  1  active-low reset for core/AXI logic
- rst_mac_n_o  output  1  active-low reset for MAC/PHY-interface logic
- ready_o  output  1  high when both resets are released (state RUN)
- lock_lost_o  output  1  sticky flag: lock dropped after core reset release
- loss_cnt_o  output  LOSS_CNT_W  saturating count of lock-loss events
- state_o  output  2  current state: WAIT=0, STABLE=1, GAP=2, RUN=3

Behaviour:
- Reset (rst_in=0, asynchronous):
  - synchroniser flops = 0, state = WAIT, internal cnt = 0;
  - rst_core_n_o = 0, rst_mac_n_o = 0, ready_o = 0, lock_lost_o = 0, loss_cnt_o = 0, state_o = 0.
- Reset deassertion takes effect at the next clk_in rising edge.
- locked_s is the output of the last synchroniser stage. No other logic samples clk_locked_i.
- All outputs are dedicated flops updated on the same edge as the state register. There is no combinational decode to the outputs.
  - rst_core_n_o = 1 exactly when state ∈ {GAP, RUN}.
  - rst_mac_n_o = 1 and ready_o = 1 exactly when state = RUN.
- Counter width is $clog2(max(STABLE_CYCLES, RST_GAP)) + 1. cnt is cleared on every state change.
- FSM transitions (evaluated each edge):
  - WAIT: if sw_rst_i=0 and locked_s=1 -> STABLE, cnt=0.
  - STABLE: if locked_s=0 or sw_rst_i=1 -> WAIT. This is not counted as a loss.
    - Else if cnt == STABLE_CYCLES-1 -> GAP.
    - Else cnt++.
    - Result: STABLE occupies exactly STABLE_CYCLES cycles.
  - GAP: if locked_s=0 -> WAIT with a loss event.
    - Else if sw_rst_i=1 -> WAIT with no loss event.
    - Else if cnt == RST_GAP-1 -> RUN.
    - Else cnt++.
  - RUN: if locked_s=0 -> WAIT with a loss event; else if sw_rst_i=1 -> WAIT. Otherwise remain in RUN.
- Precedence: locked_s=0 beats sw_rst_i when both occur in GAP/RUN, so the event is counted as a loss.
- Loss event:
  - lock_lost_o <= 1;
  - loss_cnt_o <= loss_cnt_o + 1, saturating at 2^LOSS_CNT_W - 1.
- clr_stat_i:
  - Alone: clears lock_lost_o and loss_cnt_o on the next edge.
  - Same cycle as a loss event: lock_lost_o = 1 and loss_cnt_o = 1 (the clear applies first, then the increment).
- Latency:
  - clk_locked_i rises before edge E0: rst_core_n_o rises at edge E(SYNC_STAGES+STABLE_CYCLES), and rst_mac_n_o rises RST_GAP edges later.
  - clk_locked_i falls before edge F0 while in GAP/RUN: both resets are asserted at edge F(SYNC_STAGES).
  - sw_rst_i high at edge N while in GAP/RUN: resets are asserted at edge N.
- Glitch filtering: a lock pulse or dropout shorter than one clk_in period may be missed. Any dropout seen by locked_s during STABLE restarts qualification from WAIT.
- If sw_rst_i is held high, the block stays in WAIT. Qualification restarts on the edge after sw_rst_i falls, provided locked_s=1.
- Asserting rst_in mid-sequence forces the full reset values immediately, including the statistics.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=8, RST_GAP=4, LOSS_CNT_W=2):
- Power-up: rst_in low 3 cycles, then high; clk_locked_i rises before edge 0 -> state_o 1 at edge 2; rst_core_n_o=1 at edge 10; rst_mac_n_o=1, ready_o=1, state_o=3 at edge 14; lock_lost_o=0.
- Unstable lock: clk_locked_i drops for 2 cycles during STABLE -> state_o returns to 0, rst_core_n_o stays 0, loss_cnt_o=0; after lock returns, a full 8-cycle qualification runs again before release.
- Lock loss in RUN: clk_locked_i falls before edge F0 -> at F2 rst_core_n_o=0, rst_mac_n_o=0, ready_o=0, lock_lost_o=1, loss_cnt_o=1; with lock restored, release resumes 10 and 14 edges after the restore.
- Loss during GAP plus sw_rst_i in the same cycle: loss_cnt_o increments by 1 and lock_lost_o=1. sw_rst_i alone in RUN: resets are asserted and loss_cnt_o is unchanged.
- Saturation and clear: 5 loss events -> loss_cnt_o=3 (saturated). Then clr_stat_i coincident with a 6th loss -> loss_cnt_o=1, lock_lost_o=1. Then clr_stat_i alone -> loss_cnt_o=0, lock_lost_o=0.
- Reset mid-GAP: rst_in driven low asynchronously between edges -> all outputs return to reset values without waiting for a clock edge, and statistics are cleared.
